// File: rtl/pkt_proc_ctrl_pkg.sv
// Shared types and constants for the packet/CPU sequencer.
// Imported by the sequencer top, its interface and the bench.
package pkt_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CPU_RST = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam int ERR_WR_NOT_RDY = 0;
  localparam int ERR_OVERFLOW   = 1;
  localparam int ERR_TIMEOUT    = 2;
  localparam int ERR_UNDERRUN   = 3;

  // A payload word carries a zero control byte; EOP is the first non-zero
  // control byte that follows a payload word.
  localparam int CTRL_PAYLOAD = 0;

endpackage

// File: rtl/pkt_proc_ctrl_if.sv
// Bundle of the sequencer's network, FIFO, datapath and CPU-control signals.
// The master modport drives the environment side; the slave modport is the sequencer.
interface pkt_proc_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int CTRL_WIDTH = 8
);
  import pkt_ctrl_pkg::*;

  // Handshakes: an input word is taken on a cycle with in_wr & in_rdy; reb is
  // both the FIFO read and the downstream write, only issued while out_rdy=1.
  logic                  sw_enable;
  logic                  in_wr;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_rdy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  fifo_empty;
  logic                  out_rdy;
  logic                  reb;
  logic                  cpu_rst;
  logic                  pc_en;
  logic [31:0]           pkt_count;
  logic [3:0]            err_flags;
  state_e                state;

  modport master (
    output sw_enable, in_wr, in_ctrl, mem_we, mem_addr, fifo_empty, out_rdy,
    input  in_rdy, reb, cpu_rst, pc_en, pkt_count, err_flags, state
  );

  modport slave (
    input  sw_enable, in_wr, in_ctrl, mem_we, mem_addr, fifo_empty, out_rdy,
    output in_rdy, reb, cpu_rst, pc_en, pkt_count, err_flags, state
  );

endinterface

// File: rtl/pkt_proc_ctrl_watchdog.sv
// RUN-state watchdog: loadable down-counter whose expire flag rises on the
// CYCLES-th running cycle after a load. Built only with PKT_TIMEOUT_EN.
`ifdef PKT_TIMEOUT_EN
module pkt_watchdog #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int            W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0]  LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = LOAD;
    else if (run_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = run_i & (cnt_q == '0);

endmodule
`endif

// File: rtl/pkt_proc_ctrl.sv
// Sequencer sharing the packet FIFO between the network path and the CPU:
// admit one packet, run the CPU until the done write, drain that packet.
// Optional RUN watchdog under macro PKT_TIMEOUT_EN.
module pkt_proc_ctrl
  import pkt_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    CTRL_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = {ADDR_WIDTH{1'b1}},
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input logic            clk,
  input logic            reset,
  pkt_proc_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic                  prev_payload_q, prev_payload_d;
  logic [31:0]           pkt_count_q, pkt_count_d;
  logic [3:0]            err_q, err_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  pc_en_q, pc_en_d;
  logic                  accept, eop, full, done, expire, reb;

  assign accept = bus.in_wr & in_rdy_q;
  assign eop    = accept & prev_payload_q & (bus.in_ctrl != CTRL_WIDTH'(CTRL_PAYLOAD));
  assign full   = accept & (word_cnt_q == CNT_MAX - 1'b1);
  assign done   = (state_q == ST_RUN) & bus.mem_we & (bus.mem_addr == DONE_ADDR);

`ifdef PKT_TIMEOUT_EN
  // CPU_RST always precedes RUN, so it is the natural load slot.
  pkt_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q == ST_CPU_RST),
    .run_i    (state_q == ST_RUN),
    .expire_o (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      word_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      prev_payload_q <= 1'b0;
      pkt_count_q    <= '0;
      err_q          <= '0;
      in_rdy_q       <= 1'b0;
      cpu_rst_q      <= 1'b0;
      pc_en_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      prev_payload_q <= prev_payload_d;
      pkt_count_q    <= pkt_count_d;
      err_q          <= err_d;
      in_rdy_q       <= in_rdy_d;
      cpu_rst_q      <= cpu_rst_d;
      pc_en_q        <= pc_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.sw_enable)       state_d = ST_COLLECT;
      ST_COLLECT: if (eop || full)         state_d = ST_CPU_RST;
      ST_CPU_RST:                          state_d = ST_RUN;
      ST_RUN:     if (done || expire)      state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt_q == '0)   state_d = bus.sw_enable ? ST_COLLECT : ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reb = (state_q == ST_DRAIN) & bus.out_rdy & ~bus.fifo_empty & (drain_cnt_q != '0);

    in_rdy_d       = (state_d == ST_COLLECT);
    cpu_rst_d      = (state_d == ST_CPU_RST);
    pc_en_d        = (state_d == ST_RUN);
    word_cnt_d     = word_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    prev_payload_d = prev_payload_q;
    pkt_count_d    = pkt_count_q;
    err_d          = err_q;

    if (accept) begin
      word_cnt_d     = word_cnt_q + 1'b1;
      prev_payload_d = (bus.in_ctrl == CTRL_WIDTH'(CTRL_PAYLOAD));
    end
    if (bus.in_wr && !in_rdy_q)                     err_d[ERR_WR_NOT_RDY] = 1'b1;
    if (state_q == ST_COLLECT && full && !eop)      err_d[ERR_OVERFLOW]   = 1'b1;
    // A done write in the expiry cycle takes priority over the timeout.
    if (state_q == ST_RUN && expire && !done)       err_d[ERR_TIMEOUT]    = 1'b1;
    if (state_q == ST_RUN && (done || expire))      drain_cnt_d = word_cnt_q;
    if (reb)                                        drain_cnt_d = drain_cnt_q - 1'b1;
    if (state_q == ST_DRAIN && bus.out_rdy && bus.fifo_empty && drain_cnt_q != '0)
      err_d[ERR_UNDERRUN] = 1'b1;
    if (state_q == ST_DRAIN && drain_cnt_q == '0) begin
      pkt_count_d    = pkt_count_q + 32'd1;
      word_cnt_d     = '0;
      prev_payload_d = 1'b0;
    end
  end

  assign bus.in_rdy    = in_rdy_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.pc_en     = pc_en_q;
  assign bus.reb       = reb;
  assign bus.pkt_count = pkt_count_q;
  assign bus.err_flags = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pkt_proc_ctrl.sv
// Directed bench for pkt_proc_ctrl; expected drain lengths are queued when a
// packet is sent and checked against counted reb pulses when it completes.
module tb_pkt_proc_ctrl;
  import pkt_ctrl_pkg::*;

  localparam logic [9:0] DONE = 10'h3FF;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pkts  = 0;
  logic [15:0] exp_q[$];

  pkt_proc_ctrl_if #(.ADDR_WIDTH(10), .CTRL_WIDTH(8)) bus ();

  pkt_proc_ctrl #(
    .ADDR_WIDTH(10), .CTRL_WIDTH(8), .DONE_ADDR(DONE), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit has_eop);
    exp_q.push_back(16'(n));
    for (int i = 0; i < n; i++) begin
      check("in_rdy_word", 32'(bus.in_rdy), 32'd1);
      bus.in_wr   = 1'b1;
      bus.in_ctrl = (i == 0) ? 8'hFF : ((has_eop && i == n - 1) ? 8'h01 : 8'h00);
      cyc();
    end
    bus.in_wr   = 1'b0;
    bus.in_ctrl = 8'h00;
  endtask

  task automatic done_write(input logic [9:0] addr);
    bus.mem_we   = 1'b1;
    bus.mem_addr = addr;
    cyc();
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
  endtask

  task automatic wait_pkt(input int budget);
    int i = 0;
    pkts++;
    while (bus.pkt_count != 32'(pkts) && i < budget) begin
      cyc();
      i++;
    end
    check("pkt_done", bus.pkt_count, 32'(pkts));
  endtask

  // Scoreboard side: count reb pulses per packet, compare on completion.
  int          reb_cnt  = 0;
  logic [31:0] last_pkt = '0;
  always @(negedge clk) begin
    if (reset) begin
      reb_cnt  = 0;
      last_pkt = '0;
    end else begin
      if (bus.reb) reb_cnt++;
      if (bus.pkt_count != last_pkt) begin
        check("pkt_count_step", bus.pkt_count, last_pkt + 32'd1);
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_pop: observed packet with %0d reb, expected none", reb_cnt);
        end
        if (exp_q.size() != 0) check("reb_per_pkt", 32'(reb_cnt), 32'(exp_q.pop_front()));
        reb_cnt  = 0;
        last_pkt = bus.pkt_count;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.sw_enable  = 1'b0;
    bus.in_wr      = 1'b0;
    bus.in_ctrl    = 8'h00;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.fifo_empty = 1'b0;
    bus.out_rdy    = 1'b1;
    repeat (2) cyc();
    check("rst_state",   32'(bus.state), 32'(ST_IDLE));
    check("rst_in_rdy",  32'(bus.in_rdy), 32'd0);
    check("rst_pc_en",   32'(bus.pc_en), 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("rst_pkt",     bus.pkt_count, 32'd0);
    check("rst_err",     32'(bus.err_flags), 32'd0);
    reset = 1'b0;
    cyc();
    check("idle_in_rdy", 32'(bus.in_rdy), 32'd0);

    // Basic 6-word packet.
    bus.sw_enable = 1'b1;
    cyc();
    check("collect_state", 32'(bus.state), 32'(ST_COLLECT));
    send_pkt(6, 1'b1);
    check("eop_in_rdy",  32'(bus.in_rdy), 32'd0);
    check("eop_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("eop_pc_en",   32'(bus.pc_en), 32'd0);
    cyc();
    check("run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("run_pc_en",   32'(bus.pc_en), 32'd1);
    check("run_state",   32'(bus.state), 32'(ST_RUN));
    done_write(DONE - 10'd1);
    check("near_done_state", 32'(bus.state), 32'(ST_RUN));
    check("near_done_pc_en", 32'(bus.pc_en), 32'd1);
    check("run_reb",         32'(bus.reb), 32'd0);
    cyc();
    done_write(DONE);
    check("done_pc_en", 32'(bus.pc_en), 32'd0);
    check("done_state", 32'(bus.state), 32'(ST_DRAIN));
    check("done_reb",   32'(bus.reb), 32'd1);
    wait_pkt(50);
    check("after1_state", 32'(bus.state), 32'(ST_COLLECT));

    // Drain with out_rdy toggling.
    send_pkt(6, 1'b1);
    cyc();
    done_write(DONE);
    for (int i = 0; i < 12; i++) begin
      bus.out_rdy = (i % 2 == 0);
      #1;
      check("reb_gated", 32'(bus.reb), 32'(bus.out_rdy));
      cyc();
    end
    bus.out_rdy = 1'b1;
    wait_pkt(50);
    check("after2_state", 32'(bus.state), 32'(ST_COLLECT));
    check("after2_err",   32'(bus.err_flags), 32'd0);

    // sw_enable dropped mid-packet, then a write while idle.
    send_pkt(4, 1'b1);
    cyc();
    bus.sw_enable = 1'b0;
    repeat (2) cyc();
    check("swoff_run", 32'(bus.state), 32'(ST_RUN));
    done_write(DONE);
    wait_pkt(50);
    check("swoff_idle",   32'(bus.state), 32'(ST_IDLE));
    check("swoff_in_rdy", 32'(bus.in_rdy), 32'd0);
    bus.in_wr = 1'b1;
    cyc();
    bus.in_wr = 1'b0;
    check("idle_wr_err", 32'(bus.err_flags), 32'd1);
    check("idle_wr_state", 32'(bus.state), 32'(ST_IDLE));

`ifdef PKT_TIMEOUT_EN
    // Done write in the 16th RUN cycle beats the watchdog.
    bus.sw_enable = 1'b1;
    cyc();
    send_pkt(4, 1'b1);
    cyc();
    repeat (15) cyc();
    check("wd16_pc_en", 32'(bus.pc_en), 32'd1);
    done_write(DONE);
    check("wd_done_pc_en", 32'(bus.pc_en), 32'd0);
    check("wd_done_err2",  32'(bus.err_flags[ERR_TIMEOUT]), 32'd0);
    wait_pkt(50);
    // No done write: the watchdog forces the drain.
    send_pkt(4, 1'b1);
    cyc();
    repeat (15) cyc();
    check("wd_pc_en_hi", 32'(bus.pc_en), 32'd1);
    cyc();
    check("wd_pc_en_lo", 32'(bus.pc_en), 32'd0);
    check("wd_err2",     32'(bus.err_flags[ERR_TIMEOUT]), 32'd1);
    check("wd_state",    32'(bus.state), 32'(ST_DRAIN));
    wait_pkt(50);
`endif

    // Overflow: a full-size packet with no EOP.
    bus.sw_enable = 1'b1;
    cyc();
    send_pkt(1023, 1'b0);
    check("ovf_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("ovf_err1",    32'(bus.err_flags[ERR_OVERFLOW]), 32'd1);
    cyc();
    done_write(DONE);
    wait_pkt(1200);
    cyc();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a drain.
    send_pkt(6, 1'b1);
    cyc();
    done_write(DONE);
    repeat (3) cyc();
    check("mid_drain_reb", 32'(bus.reb), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    check("rst2_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst2_reb",   32'(bus.reb), 32'd0);
    check("rst2_pc_en", 32'(bus.pc_en), 32'd0);
    check("rst2_pkt",   bus.pkt_count, 32'd0);
    check("rst2_err",   32'(bus.err_flags), 32'd0);
    reset = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_proc_ctrl.md
# pkt_proc_ctrl

Sequencer that shares the packet FIFO/SRAM between the network path and the embedded CPU datapath. It admits one packet into the FIFO, then stalls input and starts the CPU (reset pulse, then `pc_en`). When the CPU signals completion by writing the done address, it drains exactly that packet to the output before admitting the next. It sits between the software enable register, the FIFO/SRAM block and the datapath, replacing the free-running `pc_en`/`reb` glue.

## Interface
- `ADDR_WIDTH`, default 10: SRAM address width; also sets the width of the per-packet word counter.
- `CTRL_WIDTH`, default 8: width of the FIFO control byte.
- `DONE_ADDR`, default 10'h3FF: datapath port-B write to this address means "packet done".
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in RUN (used only with `PKT_TIMEOUT_EN`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `sw_enable`  in  1  software enable; sampled at packet boundaries.
- `in_wr`  in  1  input word write strobe (FIFO write side).
- `in_ctrl`  in  CTRL_WIDTH  control byte of the input word.
- `in_rdy`  out  1  ready to accept input words; reset 0.
- `mem_we`  in  1  datapath port-B write enable.
- `mem_addr`  in  ADDR_WIDTH  datapath port-B address.
- `fifo_empty`  in  1  FIFO empty flag.
- `out_rdy`  in  1  downstream ready.
- `reb`  out  1  FIFO read / out_wr strobe; reset 0.
- `cpu_rst`  out  1  one-cycle CPU restart pulse; reset 0.
- `pc_en`  out  1  CPU run enable; reset 0.
- `pkt_count`  out  32  packets completed; reset 0.
- `err_flags`  out  4  sticky: [0] write while not ready, [1] overflow, [2] timeout, [3] drain underrun; reset 0.

## Operation
- States: IDLE, COLLECT, CPU_RST, RUN, DRAIN. Reset enters IDLE.
- IDLE: all strobes 0. Moves to COLLECT the cycle after `sw_enable`=1.
- COLLECT:
  - `in_rdy`=1. Each `in_wr` increments `word_cnt`.
  - End of packet is an accepted word with `in_ctrl`≠0 whose predecessor had `in_ctrl`=0. On that word, go to CPU_RST.
  - If `word_cnt` reaches 2^ADDR_WIDTH−1 with no EOP: set err[1] and go to CPU_RST.
- CPU_RST: `in_rdy`=0, `cpu_rst`=1 for exactly one cycle, then RUN.
- RUN:
  - `pc_en`=1.
  - `mem_we`=1 with `mem_addr`==DONE_ADDR means done: `pc_en` drops next cycle and the state goes to DRAIN with `drain_cnt`=`word_cnt`.
- DRAIN:
  - `reb` = `out_rdy` & ~`fifo_empty` & (`drain_cnt`≠0). `drain_cnt` decrements on each `reb`.
  - If `fifo_empty` while `drain_cnt`≠0 and `out_rdy`: set err[3] and keep waiting.
  - At `drain_cnt`=0: `pkt_count`+1, clear `word_cnt`. Go to COLLECT if `sw_enable`, else IDLE.
- `sw_enable` deassertion mid-packet does not abort; it takes effect at the packet boundary only.
- `in_wr` while `in_rdy`=0: the word is not counted and err[0] is set.
- `pkt_count` wraps modulo 2^32. `err_flags` clear only on `reset`.

## Timing
- All outputs are registered except `reb`, which is combinational from state, `drain_cnt`, `out_rdy` and `fifo_empty`.
- EOP word accepted in cycle N:
  - `in_rdy`=0 and `cpu_rst`=1 in N+1.
  - `pc_en`=1 from N+2.
- Done write in cycle M: `pc_en`=0 in M+1; the first `reb` is possible in M+1.
- The EOP word and a new SOP in the same packet cannot coincide; the word after EOP is blocked by `in_rdy`=0.
- Done write and watchdog expiry in the same cycle: done wins and err[2] is not set.
- `reset` asserted in any state: next cycle IDLE, all outputs at reset values, counters cleared.

## Configuration
- Macro `PKT_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in RUN.
  - On reaching TIMEOUT_CYCLES: set err[2], drop `pc_en`, and go to DRAIN as if done. The packet is forwarded unmodified by the CPU.
- Undefined: no counter; RUN waits indefinitely for the done write and err[2] stays 0.

## Structure
- Package `pkt_ctrl_pkg`:
  - State enum.
  - Error bit index constants.
  - EOP detection helper constant (`CTRL_PAYLOAD` = 0).
- Sub-module `pkt_watchdog`: loadable down-counter with expire flag. Instantiated only under `PKT_TIMEOUT_EN`.

## Test plan
- 6-word packet (ctrl 0xFF, 0×4 payload, 0x01), `sw_enable`=1 → `in_rdy` falls after word 6, `cpu_rst` pulses once, `pc_en` rises the next cycle. After a DONE_ADDR write, exactly 6 `reb` pulses occur and `pkt_count`=1.
- `out_rdy` toggling 1/0 during DRAIN → `reb` only when `out_rdy`=1; exactly 6 pulses in total; returns to COLLECT.
- Write to DONE_ADDR−1 during RUN → no state change. Write to DONE_ADDR → DRAIN.
- With `PKT_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no done write → `pc_en` drops after 16 cycles, err[2]=1, and the packet drains. Done write on cycle 16 → err[2]=0.
- `sw_enable` cleared in RUN → current packet completes, `pkt_count`+1, then IDLE with `in_rdy`=0. `in_wr` pulse in IDLE → err[0]=1.
- `reset` pulsed in DRAIN with 3 words left → next cycle `reb`=0, `pc_en`=0, `pkt_count`=0, `err_flags`=0, state IDLE.
